// File: rtl/rx_packet_sequencer.sv
// Receive packet sequencer: hunts for a preamble, locks symbol timing, checks the
// access address and streams header, payload and CRC bits with framing pulses.
module rx_packet_sequencer #(
  parameter int SAMPLE_RATE   = 16,
  parameter int MAX_AA_ERRORS = 0,
  parameter int CRC_BITS      = 24
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_en,
  input  logic        i_data_bit,
  input  logic        i_preamble_detected,
  input  logic [31:0] i_access_addr,
  input  logic        i_abort,
  output logic        o_det_en,
  output logic        o_busy,
  output logic        o_bit_strobe,
  output logic        o_bit_out,
  output logic [7:0]  o_pdu_length,
  output logic        o_pkt_start,
  output logic        o_pkt_done,
  output logic        o_aa_error
);

  // state     | meaning
  // S_SEARCH  | idle, preamble detector enabled
  // S_ACCESS  | sampling and checking the 32 access-address bits
  // S_HEADER  | streaming 16 header bits, length byte captured from bits 8..15
  // S_PAYLOAD | streaming payload and CRC bits until the remaining count expires
  typedef enum logic [1:0] {S_SEARCH, S_ACCESS, S_HEADER, S_PAYLOAD} state_t;

  localparam int              PH_W    = $clog2(SAMPLE_RATE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLE_RATE - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [5:0]      MAX_AA  = 6'(MAX_AA_ERRORS);
  localparam logic [15:0]     CRC16   = 16'(CRC_BITS);

  state_t          r_state, w_state_nx;
  logic [PH_W-1:0] r_ph, w_ph_nx;
  logic [4:0]      r_bc, w_bc_nx;
  logic [5:0]      r_mc, w_mc_nx;
  logic [15:0]     r_rem, w_rem_nx;
  logic [7:0]      r_len, w_len_nx;
  logic            r_busy, w_busy_nx;
  logic            r_strobe, w_strobe_nx;
  logic            r_bit_out, w_bit_out_nx;
  logic            r_start, w_start_nx;
  logic            r_done, w_done_nx;
  logic            r_aa_err, w_aa_err_nx;

  logic            w_sample;
  logic            w_mis;
  logic [5:0]      w_mc_inc;
  logic [7:0]      w_len_shift;

  assign w_sample    = i_en && (r_ph == PH_LAST);
  assign w_mis       = i_data_bit ^ i_access_addr[r_bc];
  assign w_mc_inc    = r_mc + {5'd0, w_mis};
  assign w_len_shift = {i_data_bit, r_len[7:1]};

  always_comb begin
    w_state_nx   = r_state;
    w_ph_nx      = r_ph;
    w_bc_nx      = r_bc;
    w_mc_nx      = r_mc;
    w_rem_nx     = r_rem;
    w_len_nx     = r_len;
    w_bit_out_nx = r_bit_out;
    w_strobe_nx  = 1'b0;
    w_start_nx   = 1'b0;
    w_done_nx    = 1'b0;
    w_aa_err_nx  = 1'b0;

    if (i_abort) begin
      w_state_nx = S_SEARCH;
    end else if (i_en) begin
      if (r_state != S_SEARCH) begin
        w_ph_nx = w_sample ? '0 : r_ph + PH_ONE;
      end
      case (r_state)
        S_SEARCH: begin
          if (i_preamble_detected) begin
            w_state_nx = S_ACCESS;
            w_ph_nx    = '0;
            w_bc_nx    = '0;
            w_mc_nx    = '0;
          end
        end
        S_ACCESS: begin
          if (w_sample) begin
            w_mc_nx = w_mc_inc;
            // Reject as soon as the tolerance is exceeded rather than at bit 31.
            if (w_mc_inc > MAX_AA) begin
              w_state_nx  = S_SEARCH;
              w_aa_err_nx = 1'b1;
            end else if (r_bc == 5'd31) begin
              w_state_nx = S_HEADER;
              w_start_nx = 1'b1;
              w_bc_nx    = '0;
            end else begin
              w_bc_nx = r_bc + 5'd1;
            end
          end
        end
        S_HEADER: begin
          if (w_sample) begin
            w_strobe_nx  = 1'b1;
            w_bit_out_nx = i_data_bit;
            if (r_bc[3]) w_len_nx = w_len_shift;
            if (r_bc == 5'd15) begin
              w_state_nx = S_PAYLOAD;
              w_rem_nx   = ({8'd0, w_len_shift} << 3) + CRC16;
            end else begin
              w_bc_nx = r_bc + 5'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_sample) begin
            w_strobe_nx  = 1'b1;
            w_bit_out_nx = i_data_bit;
            w_rem_nx     = r_rem - 16'd1;
            if (r_rem <= 16'd1) begin
              w_done_nx  = 1'b1;
              w_state_nx = S_SEARCH;
            end
          end
        end
        default: w_state_nx = S_SEARCH;
      endcase
    end
    w_busy_nx = (w_state_nx != S_SEARCH);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_SEARCH;
      r_ph      <= '0;
      r_bc      <= '0;
      r_mc      <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_busy    <= 1'b0;
      r_strobe  <= 1'b0;
      r_bit_out <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_aa_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ph      <= w_ph_nx;
      r_bc      <= w_bc_nx;
      r_mc      <= w_mc_nx;
      r_rem     <= w_rem_nx;
      r_len     <= w_len_nx;
      r_busy    <= w_busy_nx;
      r_strobe  <= w_strobe_nx;
      r_bit_out <= w_bit_out_nx;
      r_start   <= w_start_nx;
      r_done    <= w_done_nx;
      r_aa_err  <= w_aa_err_nx;
    end
  end

  assign o_det_en     = i_en & (r_state == S_SEARCH);
  assign o_busy       = r_busy;
  assign o_bit_strobe = r_strobe;
  assign o_bit_out    = r_bit_out;
  assign o_pdu_length = r_len;
  assign o_pkt_start  = r_start;
  assign o_pkt_done   = r_done;
  assign o_aa_error   = r_aa_err;

endmodule
